// File: rtl/mmc1_mapper.sv
// MMC1-compatible PRG/CHR bank mapper with M2-synchronised serial register port.
// Optional macro MMC1_CONSEC_FILTER_EN drops a write that immediately follows another write cycle.
module mmc1_mapper #(
  parameter int SYNC_STAGES   = 2,
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5
) (
  input  logic                       clk,
  input  logic                       async_nreset,
  input  logic                       en,
  input  logic                       m2,
  input  logic                       romsel,
  input  logic                       cpu_rw,
  input  logic [14:0]                cpu_addr,
  input  logic [7:0]                 cpu_data,
  input  logic [12:0]                ppu_addr,
  output logic [PRG_BANK_BITS+13:0]  prg_addr,
  output logic [CHR_BANK_BITS+11:0]  chr_addr,
  output logic                       ciram_a10,
  output logic                       wram_en,
  output logic                       reg_we
);

  logic [SYNC_STAGES-1:0] m2_sync;
  logic       m2_s, m2_prev, m2_fall;
  logic       cap_romsel, cap_rw, cap_d7, cap_d0;
  logic [1:0] cap_sel;
  logic [4:0] control, chr0, chr1, prg, shift, next_shift;
  logic [2:0] count;
  logic       qualified, accept;
  logic [7:0] prg_wide, chr_wide;
  logic       unused_ok;

  assign m2_s       = m2_sync[SYNC_STAGES-1];
  assign m2_fall    = m2_prev & ~m2_s;
  assign qualified  = en & ~cap_romsel & ~cap_rw;
  assign next_shift = {cap_d0, shift[4:1]};

  // Bus fields are sampled only while the synchronised M2 is high, so the
  // values evaluated at the falling edge are those of the last high clock.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      m2_sync    <= '0;
      m2_prev    <= 1'b0;
      cap_romsel <= 1'b1;
      cap_rw     <= 1'b1;
      cap_sel    <= 2'd0;
      cap_d7     <= 1'b0;
      cap_d0     <= 1'b0;
    end else begin
      m2_sync <= {m2_sync[SYNC_STAGES-2:0], m2};
      m2_prev <= m2_s;
      if (m2_s) begin
        cap_romsel <= romsel;
        cap_rw     <= cpu_rw;
        cap_sel    <= cpu_addr[14:13];
        cap_d7     <= cpu_data[7];
        cap_d0     <= cpu_data[0];
      end
    end
  end

`ifdef MMC1_CONSEC_FILTER_EN
  logic last_write;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset)
      last_write <= 1'b0;
    else if (m2_fall)
      last_write <= qualified;
  end

  assign accept = m2_fall & qualified & ~last_write;
`else
  assign accept = m2_fall & qualified;
`endif

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      control <= 5'b01100;
      chr0    <= 5'd0;
      chr1    <= 5'd0;
      prg     <= 5'd0;
      shift   <= 5'd0;
      count   <= 3'd0;
      reg_we  <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      if (accept) begin
        if (cap_d7) begin
          shift   <= 5'd0;
          count   <= 3'd0;
          control <= control | 5'b01100;
        end else if (count == 3'd4) begin
          // Fifth bit: commit the assembled value straight from next_shift.
          case (cap_sel)
            2'd0:    control <= next_shift;
            2'd1:    chr0    <= next_shift;
            2'd2:    chr1    <= next_shift;
            default: prg     <= next_shift;
          endcase
          reg_we <= 1'b1;
          shift  <= 5'd0;
          count  <= 3'd0;
        end else begin
          shift <= next_shift;
          count <= count + 3'd1;
        end
      end
    end
  end

  always_comb begin
    prg_wide = 8'h00;
    case (control[3:2])
      2'd0, 2'd1: prg_wide = {4'b0, prg[3:1], cpu_addr[14]};
      2'd2:       prg_wide = cpu_addr[14] ? {4'b0, prg[3:0]} : 8'h00;
      default:    prg_wide = cpu_addr[14] ? 8'hFF : {4'b0, prg[3:0]};
    endcase
  end

  always_comb begin
    chr_wide = 8'h00;
    if (control[4])
      chr_wide = ppu_addr[12] ? {3'b0, chr1} : {3'b0, chr0};
    else
      chr_wide = {3'b0, chr0[4:1], ppu_addr[12]};
  end

  always_comb begin
    ciram_a10 = 1'b0;
    case (control[1:0])
      2'd0:    ciram_a10 = 1'b0;
      2'd1:    ciram_a10 = 1'b1;
      2'd2:    ciram_a10 = ppu_addr[10];
      default: ciram_a10 = ppu_addr[11];
    endcase
  end

  assign prg_addr = {prg_wide[PRG_BANK_BITS-1:0], cpu_addr[13:0]};
  assign chr_addr = {chr_wide[CHR_BANK_BITS-1:0], ppu_addr[11:0]};
  assign wram_en  = ~prg[4];

  assign unused_ok = ^{cpu_data[6:1], prg_wide, chr_wide, shift[0]};

endmodule
